serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor; computes diff = a - b one bit per clock, LSB first.
- Uses a single full-subtractor cell with a registered borrow. It is the inverse-direction companion to the team's ripple adder cells.
- Intended for area-constrained datapaths where WIDTH clocks of latency is acceptable.
- Start/done handshake toward the controlling FSM.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2 to 32.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request pulse; sampled only when the block is idle.
- a  input  WIDTH  minuend; captured on an accepted start.
- b  input  WIDTH  subtrahend; captured on an accepted start.
- busy  output  1  high while an operation is in progress (RUN and DONE states).
- done  output  1  single-cycle pulse; diff/bout are valid from this cycle on.
- diff  output  WIDTH  result a - b modulo 2^WIDTH.
- bout  output  1  final borrow; 1 when a < b unsigned.
- ovf  output  1  signed overflow; present only with SERIAL_SUB_OVF_EN.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Reset values:
  - state=IDLE.
  - busy=0, done=0, diff=0, bout=0, ovf=0.
  - Internal shift registers, borrow flop and bit counter are all 0.
- States:
  - IDLE: busy=0. If start=1, load a into the A shift register, b into the B shift register, clear the borrow, counter=0, go to RUN. If start=0, stay in IDLE.
  - RUN: busy=1. Each cycle:
    - d = a0 ^ b0 ^ br.
    - br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
    - Shift A and B right by one.
    - Shift d into the MSB of the result register.
    - counter++.
    - When counter reaches WIDTH-1 (the last bit is processed that cycle), go to DONE.
  - DONE: busy=1, done=1 for exactly one cycle.
    - diff presents the full result register.
    - bout = final borrow.
    - Return to IDLE.
- Latency:
  - start sampled at edge E0.
  - RUN occupies edges E1..E_WIDTH.
  - done is high in the cycle following edge E_WIDTH.
  - Total: WIDTH+1 cycles from start to done.
- Output hold: diff and bout are registered. They hold their value after done until the next accepted start completes.
- Start handling:
  - start while busy=1 (RUN or DONE) is ignored. No queuing, and operands are not re-captured.
  - Throughput: one operation per WIDTH+2 cycles (start re-asserted in the first IDLE cycle).
- Operand stability: a and b may change freely after the start cycle; only the captured copies are used.
- rst mid-operation: on the next edge, return to IDLE with all outputs cleared. The partial result is discarded and done is not asserted.
- rst and start together: rst wins; start is not accepted.
- Arithmetic: all operations are unsigned and modulo 2^WIDTH. No sign extension. bout equals the carry-out of the borrow chain at the MSB.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - Port ovf exists.
  - ovf = (a_msb ^ b_msb) & (a_msb ^ diff_msb), evaluated on the captured operands.
  - ovf is registered in the DONE transition, held alongside diff, and reset to 0.
- Undefined:
  - Port ovf and all associated logic are absent.
  - Operand MSB capture flops are not instantiated.

Test Plan:
- WIDTH=8; a=100, b=37, start pulse -> done exactly 9 cycles after start; diff=63, bout=0, busy high 9 cycles.
- a=5, b=9 -> diff=252 (0xFC), bout=1; a=0xFF, b=0x01 -> diff=0xFE, bout=0; a=0, b=0 -> diff=0, bout=0.
- Busy rejection: start a=10, b=3; re-pulse start with a=1, b=2 at cycles 3 and 8 -> single done, diff=7, no second operation.
- Reset mid-op: start a=200, b=50; assert rst at cycle 4 -> next cycle busy=0, diff=0, no done pulse; new start a=200, b=50 -> diff=150.
- Back-to-back: start asserted continuously -> operations accepted every 10 cycles; diff/bout hold between done pulses.
- With SERIAL_SUB_OVF_EN: a=0x80, b=0x01 -> diff=0x7F, ovf=1; a=0x10, b=0x01 -> diff=0x0F, ovf=0.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b, LSB first) with start/done handshake.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh, b_sh, res_q, res_nx;
  logic [CW-1:0]    cnt_q;
  logic             br_q, br_nx, d, last;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;

  // Full-subtractor cell on the current LSBs with the registered borrow.
  always_comb begin
    d      = a_sh[0] ^ b_sh[0] ^ br_q;
    br_nx  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br_q);
    res_nx = {d, res_q[WIDTH-1:1]};
    last   = (cnt_q == CW'(WIDTH - 1));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb_q, b_msb_q, ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (state_q == IDLE && start) begin
      a_msb_q <= a[WIDTH-1];
      b_msb_q <= b[WIDTH-1];
    end else if (state_q == RUN && last) begin
      ovf_q <= (a_msb_q ^ b_msb_q) & (a_msb_q ^ res_nx[WIDTH-1]);
    end
  end

  assign ovf = ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_q  <= '0;
      br_q   <= 1'b0;
      cnt_q  <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            res_q <= '0;
            br_q  <= 1'b0;
            cnt_q <= '0;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          res_q <= res_nx;
          br_q  <= br_nx;
          cnt_q <= cnt_q + CW'(1);
          // Publish on the final bit so diff/bout stay put until the next result.
          if (last) begin
            diff_q <= res_nx;
            bout_q <= br_nx;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed testbench for serial_subtractor (WIDTH=8); ovf checks under SERIAL_SUB_OVF_EN.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] a, b;
  logic       busy, done, bout;
  logic [7:0] diff;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf;
`endif

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .diff (diff),
    .bout (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf  (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] va;
    logic [7:0] vb;
    logic [7:0] ed;
    logic       eb;
    logic       eo;
  } vec_t;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one start, then follow the operation to completion with a bounded wait.
  task automatic run_op(input logic [7:0] va, input logic [7:0] vb,
                        input logic [7:0] ed, input logic eb, input logic eo);
    int done_at;
    int busy_n;
    start = 1'b1;
    a = va;
    b = vb;
    tick();
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    done_at = -1;
    busy_n = busy ? 1 : 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (busy) busy_n++;
      if (done && done_at < 0) begin
        done_at = n;
        check($sformatf("diff %0d-%0d", va, vb), diff, ed);
        check($sformatf("bout %0d-%0d", va, vb), bout, eb);
`ifdef SERIAL_SUB_OVF_EN
        check($sformatf("ovf %0d-%0d", va, vb), ovf, eo);
`endif
      end
      if (!busy) break;
    end
    check("done latency", done_at, 8);
    check("busy cycles", busy_n, 9);
    check("done single pulse", done, 0);
    tick();
    tick();
    check("diff hold", diff, ed);
    check("bout hold", bout, eb);
`ifdef SERIAL_SUB_OVF_EN
    check("ovf hold", ovf, eo);
`else
    if (eo) ;
`endif
  endtask

  initial begin
    vec_t vecs[9];
    int   ndone;
    vecs[0] = '{8'd100, 8'd37,  8'd63,  1'b0, 1'b0};
    vecs[1] = '{8'd5,   8'd9,   8'hFC,  1'b1, 1'b0};
    vecs[2] = '{8'hFF,  8'h01,  8'hFE,  1'b0, 1'b0};
    vecs[3] = '{8'h00,  8'h00,  8'h00,  1'b0, 1'b0};
    vecs[4] = '{8'h80,  8'h01,  8'h7F,  1'b0, 1'b1};
    vecs[5] = '{8'h10,  8'h01,  8'h0F,  1'b0, 1'b0};
    vecs[6] = '{8'h00,  8'h01,  8'hFF,  1'b1, 1'b0};
    vecs[7] = '{8'h7F,  8'hFF,  8'h80,  1'b1, 1'b1};
    vecs[8] = '{8'hAA,  8'h55,  8'h55,  1'b0, 1'b1};

    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    tick();
    tick();
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset diff", diff, 0);
    check("reset bout", bout, 0);
`ifdef SERIAL_SUB_OVF_EN
    check("reset ovf", ovf, 0);
`endif
    // rst and start together: start must not be accepted
    start = 1'b1;
    a = 8'd9;
    b = 8'd4;
    tick();
    check("rst+start busy", busy, 0);
    rst = 1'b0;
    start = 1'b0;
    tick();
    check("idle after rst+start", busy, 0);

    foreach (vecs[i]) run_op(vecs[i].va, vecs[i].vb, vecs[i].ed, vecs[i].eb, vecs[i].eo);

    // Busy rejection: extra starts in cycles 3 and 8 are ignored
    start = 1'b1;
    a = 8'd10;
    b = 8'd3;
    tick();
    start = 1'b0;
    ndone = 0;
    for (int n = 1; n <= 14; n++) begin
      if (done) begin
        ndone++;
        check("reject diff", diff, 7);
        check("reject bout", bout, 0);
      end
      start = (n == 2 || n == 7);
      a = 8'd1;
      b = 8'd2;
      tick();
    end
    start = 1'b0;
    check("reject done count", ndone, 1);
    check("reject idle", busy, 0);
    check("reject diff hold", diff, 7);

    // Reset mid-operation
    start = 1'b1;
    a = 8'd200;
    b = 8'd50;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst busy", busy, 0);
    check("midrst diff", diff, 0);
    check("midrst bout", bout, 0);
    ndone = 0;
    for (int n = 0; n < 12; n++) begin
      if (done) ndone++;
      tick();
    end
    check("midrst no done", ndone, 0);
    run_op(8'd200, 8'd50, 8'd150, 1'b0, 1'b0);

    // Back-to-back with start held high; operands change after first capture
    start = 1'b1;
    a = 8'd20;
    b = 8'd30;
    tick();
    for (int n = 1; n <= 30; n++) begin
      tick();
      a = 8'd50;
      b = 8'd8;
      check($sformatf("b2b done n=%0d", n), done, (n == 8 || n == 18 || n == 28) ? 1 : 0);
      if (n >= 8) begin
        check($sformatf("b2b diff n=%0d", n), diff, (n < 18) ? 246 : 42);
        check($sformatf("b2b bout n=%0d", n), bout, (n < 18) ? 1 : 0);
      end
    end
    start = 1'b0;
    for (int n = 0; n < 12; n++) tick();
    check("b2b final idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
